// File: rtl/harris_pkg.sv
// rtl/harris_pkg.sv - shared pixel/window types and FSM states for the Harris window source
package harris_pkg;

    localparam int PIX_W = 8;
    localparam int WIN   = 6;

    typedef logic [PIX_W-1:0] pix_t;
    typedef pix_t [0:WIN-1][0:WIN-1] window_t;

    typedef enum logic [1:0] {
        FILL,
        RUN,
        DONE
    } state_t;

endpackage

// File: rtl/harris_line_buf.sv
// rtl/harris_line_buf.sv - one image row of pixel storage, read-before-write at a shared address
module harris_line_buf #(
    parameter int IMG_W = 64,
    parameter int PIX_W = 8
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(IMG_W)-1:0] addr_i,
    input  logic [PIX_W-1:0]         wr_data_i,
    output logic [PIX_W-1:0]         rd_data_o
);

    logic [PIX_W-1:0] mem_q [IMG_W];

    // Contents need no reset: the window source gates validity with its counters.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[addr_i];

endmodule

// File: rtl/harris_window_src.sv
// rtl/harris_window_src.sv - raster pixel stream to registered WIN x WIN windows tagged with pixel count
module harris_window_src
    import harris_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_valid,
    output logic             pix_ready,
    output window_t          window,
    output logic             win_valid,
    input  logic             win_ready,
    output logic [63:0]      count,
    output logic             frame_done
);

    localparam int COL_W = $clog2(IMG_W);
    localparam int ROW_W = $clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_LAST      = COL_W'(IMG_W - 1);
    localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(WIN - 1);
    localparam logic [ROW_W-1:0] ROW_LAST      = ROW_W'(IMG_H - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST_WIN = ROW_W'(WIN - 1);

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    window_t          window_q, window_d;
    logic             win_valid_q, win_valid_d;
    logic [63:0]      count_q, count_d;
    logic             frame_done_q, frame_done_d;

    logic accept;
    logic load;
    pix_t lb_rd [WIN-1];

    assign pix_ready = (state_q != DONE) && (!win_valid_q || win_ready);
    assign accept    = pix_valid && pix_ready;
    assign load      = accept && (row_q >= ROW_FIRST_WIN) && (col_q >= COL_FIRST_WIN);

    // Buffer 0 holds the oldest row; each accept pushes every row one buffer older.
    for (genvar k = 0; k < WIN - 1; k++) begin : g_line
        pix_t wr_data;
        if (k == WIN - 2) begin : g_newest
            assign wr_data = pix_in;
        end else begin : g_older
            assign wr_data = lb_rd[k+1];
        end
        harris_line_buf #(
            .IMG_W (IMG_W),
            .PIX_W (PIX_W)
        ) u_line_buf (
            .clk       (clk),
            .we_i      (accept),
            .addr_i    (col_q),
            .wr_data_i (wr_data),
            .rd_data_o (lb_rd[k])
        );
    end

    always_comb begin
        state_d      = state_q;
        row_d        = row_q;
        col_d        = col_q;
        window_d     = window_q;
        win_valid_d  = win_valid_q;
        count_d      = count_q;
        frame_done_d = 1'b0;

        if (win_valid_q && win_ready) begin
            win_valid_d = 1'b0;
        end

        if (accept) begin
            for (int r = 0; r < WIN; r++) begin
                for (int c = 0; c < WIN - 1; c++) begin
                    window_d[r][c] = window_q[r][c+1];
                end
            end
            for (int r = 0; r < WIN - 1; r++) begin
                window_d[r][WIN-1] = lb_rd[r];
            end
            window_d[WIN-1][WIN-1] = pix_in;

            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (load) begin
                win_valid_d = 1'b1;
                count_d     = 64'(row_q) * 64'(IMG_W) + 64'(col_q);
            end
        end

        case (state_q)
            FILL: begin
                if (accept && row_d == ROW_FIRST_WIN) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (accept && row_q == ROW_LAST && col_q == COL_LAST) begin
                    state_d = DONE;
                    row_d   = '0;
                    col_d   = '0;
                end
            end
            DONE: begin
                if (!win_valid_q || win_ready) begin
                    frame_done_d = 1'b1;
                    state_d      = FILL;
                    row_d        = '0;
                    col_d        = '0;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= FILL;
            row_q        <= '0;
            col_q        <= '0;
            window_q     <= '0;
            win_valid_q  <= 1'b0;
            count_q      <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            row_q        <= row_d;
            col_q        <= col_d;
            window_q     <= window_d;
            win_valid_q  <= win_valid_d;
            count_q      <= count_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign window     = window_q;
    assign win_valid  = win_valid_q;
    assign count      = count_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_harris_window_src.sv
// tb/tb_harris_window_src.sv - directed self-checking bench for harris_window_src on an 8x8 image
module tb_harris_window_src;
    import harris_pkg::*;

    localparam int W    = 8;
    localparam int H    = 8;
    localparam int NPIX = W * H;
    localparam int NWIN = 9;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  pix_in = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    window_t     window;
    logic        win_valid;
    logic        win_ready = 1'b0;
    logic [63:0] count;
    logic        frame_done;

    int n_tests = 0;
    int n_fail  = 0;
    int exp_counts [NWIN] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

    harris_window_src #(
        .IMG_W (W),
        .IMG_H (H)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .pix_in     (pix_in),
        .pix_valid  (pix_valid),
        .pix_ready  (pix_ready),
        .window     (window),
        .win_valid  (win_valid),
        .win_ready  (win_ready),
        .count      (count),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pix(input int base, input int idx);
        return 8'((base + idx) & 255);
    endfunction

    task automatic check_window(input int base, input int k);
        int r;
        int c;
        logic [47:0] er;
        r = k / W;
        c = k % W;
        for (int i = 0; i < WIN; i++) begin
            er = '0;
            for (int j = 0; j < WIN; j++) begin
                er[(WIN-1-j)*8 +: 8] = pix(base, (r - WIN + 1 + i) * W + c - WIN + 1 + j);
            end
            check($sformatf("win_row%0d_k%0d", i, k), 64'(window[i]), 64'(er));
        end
    endtask

    // mode 0: always valid/ready, 1: stall the first window 3 cycles, 2: random pix_valid
    task automatic run_frame(input int base, input int mode);
        int pi;
        int wi;
        int fd;
        int hold;
        logic pv;
        logic wr;
        pi = 0;
        wi = 0;
        fd = 0;
        hold = 0;
        for (int cyc = 0; cyc < 600 && fd == 0; cyc++) begin
            @(negedge clk);
            pv = (pi < NPIX) && (mode != 2 || $urandom_range(0, 1) == 1);
            wr = 1'b1;
            if (mode == 1 && win_valid && wi == 0 && hold < 3) begin
                wr = 1'b0;
                hold++;
            end
            pix_valid = pv;
            pix_in    = pix(base, pi);
            win_ready = wr;
            #1;
            if (!wr) begin
                check("bp_count", count, 64'd45);
                check("bp_newest", 64'(window[WIN-1][WIN-1]), 64'(pix(base, 45)));
                check("bp_pix_ready", 64'(pix_ready), 64'd0);
            end
            if (frame_done) begin
                fd++;
                check("frame_done_after_last_win", 64'(wi), 64'(NWIN));
            end
            if (pi == NPIX && fd == 0) begin
                check("done_pix_ready", 64'(pix_ready), 64'd0);
            end
            if (win_valid) begin
                check("no_early_win", 64'(pi >= 46), 64'd1);
            end
            if (win_valid && win_ready) begin
                if (wi < NWIN) begin
                    check($sformatf("count_%0d", wi), count, 64'(exp_counts[wi]));
                    check_window(base, exp_counts[wi]);
                end else begin
                    check("extra_window", count, 64'd0);
                end
                wi++;
            end
            if (pix_valid && pix_ready) begin
                pi++;
            end
        end
        pix_valid = 1'b0;
        check("frame_pixels", 64'(pi), 64'(NPIX));
        check("frame_windows", 64'(wi), 64'(NWIN));
        check("frame_done_pulses", 64'(fd), 64'd1);
    endtask

    initial begin
        int pi;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        win_ready = 1'b0;
        #1;
        check("rst_win_valid", 64'(win_valid), 64'd0);
        check("rst_count", count, 64'd0);
        check("rst_frame_done", 64'(frame_done), 64'd0);
        check("rst_window_zero", 64'(window == '0), 64'd1);
        check("rst_pix_ready", 64'(pix_ready), 64'd1);

        run_frame(0, 0);
        run_frame(100, 0);
        run_frame(0, 1);
        run_frame(7, 2);

        pi = 0;
        for (int cyc = 0; cyc < 100 && pi < 30; cyc++) begin
            @(negedge clk);
            pix_valid = 1'b1;
            pix_in    = pix(200, pi);
            win_ready = 1'b1;
            #1;
            if (pix_ready) begin
                pi++;
            end
        end
        check("partial_pixels", 64'(pi), 64'd30);
        @(negedge clk);
        pix_valid = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("midrst_win_valid", 64'(win_valid), 64'd0);
        check("midrst_count", count, 64'd0);
        check("midrst_frame_done", 64'(frame_done), 64'd0);
        check("midrst_pix_ready", 64'(pix_ready), 64'd1);

        run_frame(50, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
